// File: rtl/cpu_gen2_pkg.sv
// cpu_gen2_pkg
// Shared definitions for the cpu_gen2 processor.
// Contents:
//   - 3-bit opcode constants.
//   - FSM state encoding (state_t).
//   - Helper that classifies the opcodes that take the 3-step ALU path.
package cpu_gen2_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    // T0 = fetch, T1..T3 = execute steps.
    typedef enum logic [1:0] {
        S_T0 = 2'd0,
        S_T1 = 2'd1,
        S_T2 = 2'd2,
        S_T3 = 2'd3
    } state_t;

    // add/sub/and/or go through the A/G registers over T1..T3.
    function automatic logic is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/cpu_gen2_regfile.sv
// cpu_gen2_regfile
// General-purpose register file: one synchronous write port, all registers
// readable combinationally. All registers clear on asynchronous reset.
// Ports:
//   i_clk    - rising-edge clock
//   i_rst    - asynchronous active-high reset
//   i_we     - write enable
//   i_waddr  - write register index
//   i_wdata  - write data
//   o_regs   - current value of every register
module cpu_gen2_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [$clog2(NREG)-1:0] i_waddr,
    input  logic [DW-1:0]           i_wdata,
    output logic [DW-1:0]           o_regs [NREG]
);

    logic [DW-1:0] r_regs [NREG];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_regs = r_regs;

endmodule

// File: rtl/cpu_gen2.sv
// cpu_gen2
// Multi-cycle bus-based processor. Instructions are fetched from DIN in T0
// when Run is high; move-type instructions complete in T1, ALU instructions
// run T1 (A <= Rx), T2 (G <= A op Ry, Z update), T3 (Rx <= G).
// Instruction word: DIN[IW-1:0] = {op[2:0], X[RW-1:0], Y[RW-1:0]}.
// Ports:
//   Clock       - rising-edge clock
//   Reset       - asynchronous active-high reset
//   DIN         - instruction word (T0) or immediate (T1 of mvi)
//   Run         - start request, sampled only in T0
//   Bus         - internal bus value (0 when nothing drives it)
//   Done        - high during the last step of each instruction
//   Zero        - Z flag, set when the last G result was 0
//   o_dbg_state - current FSM state, for observation
//
// Legal parameters: DW 8..32, NREG a power of 2 in 2..16, DW >= 3+2*log2(NREG).
module cpu_gen2
    import cpu_gen2_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [DW-1:0] DIN,
    input  logic          Run,
    output logic [DW-1:0] Bus,
    output logic          Done,
    output logic          Zero,
    output state_t        o_dbg_state
);

    localparam int RW = $clog2(NREG);
    localparam int IW = 3 + 2 * RW;

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_ir;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_g;
    logic            r_z;

    logic [2:0]      w_op;
    logic [RW-1:0]   w_x;
    logic [RW-1:0]   w_y;
    logic [DW-1:0]   w_regs [NREG];
    logic [DW-1:0]   w_bus;
    logic [DW-1:0]   w_alu;
    logic            w_done;
    logic            w_we;
    logic            w_a_en;
    logic            w_g_en;
    logic            w_unused_din;

    assign w_op = r_ir[IW-1 -: 3];
    assign w_x  = r_ir[2*RW-1 -: RW];
    assign w_y  = r_ir[RW-1:0];

    // Bits of DIN above the instruction field only matter as immediate data.
    assign w_unused_din = ^DIN;

    cpu_gen2_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_we    (w_we),
        .i_waddr (w_x),
        .i_wdata (w_bus),
        .o_regs  (w_regs)
    );

    // Next state, bus source select and control strobes. Everything here is
    // decoded from state and IR only, so Done is a clean one-cycle pulse.
    always_comb begin
        w_next_state = r_state;
        w_bus        = '0;
        w_done       = 1'b0;
        w_we         = 1'b0;
        w_a_en       = 1'b0;
        w_g_en       = 1'b0;
        case (r_state)
            S_T0: begin
                if (Run) begin
                    w_next_state = S_T1;
                end
            end
            S_T1: begin
                if (is_alu(w_op)) begin
                    w_bus        = w_regs[w_x];
                    w_a_en       = 1'b1;
                    w_next_state = S_T2;
                end else begin
                    w_done       = 1'b1;
                    w_next_state = S_T0;
                    case (w_op)
                        OP_MV: begin
                            w_bus = w_regs[w_y];
                            w_we  = 1'b1;
                        end
                        OP_MVI: begin
                            w_bus = DIN;
                            w_we  = 1'b1;
                        end
                        OP_MVNZ: begin
                            w_bus = w_regs[w_y];
                            w_we  = ~r_z;
                        end
                        default: begin
                            // nop: bus stays 0, nothing written
                        end
                    endcase
                end
            end
            S_T2: begin
                w_bus        = w_regs[w_y];
                w_g_en       = 1'b1;
                w_next_state = S_T3;
            end
            S_T3: begin
                w_bus        = r_g;
                w_we         = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_T0;
            end
            default: begin
                w_next_state = S_T0;
            end
        endcase
    end

    // ALU: add/sub wrap modulo 2^DW, carry/borrow dropped.
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = r_a + w_bus;
            OP_SUB:  w_alu = r_a - w_bus;
            OP_AND:  w_alu = r_a & w_bus;
            OP_OR:   w_alu = r_a | w_bus;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_T0;
            r_ir    <= '0;
            r_a     <= '0;
            r_g     <= '0;
            r_z     <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_T0) && Run) begin
                r_ir <= DIN[IW-1:0];
            end
            if (w_a_en) begin
                r_a <= w_bus;
            end
            if (w_g_en) begin
                r_g <= w_alu;
                r_z <= (w_alu == '0);
            end
        end
    end

    assign Bus         = w_bus;
    assign Done        = w_done;
    assign Zero        = r_z;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_gen2.sv
// tb_cpu_gen2
// Bench for cpu_gen2. Two instances: DW=16/NREG=8 (directed table, reset
// abort, randomized run against an instruction-level model) and
// DW=32/NREG=16 (wide immediate and 4-bit register fields).
// Latency is counted in cycles after the fetch edge: 1 means Done in T1.
module tb_cpu_gen2;
    import cpu_gen2_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] din;
    logic        run16, run32;
    logic [15:0] din16;
    logic [15:0] bus16;
    logic        done16, zero16;
    state_t      st16;
    logic [31:0] bus32;
    logic        done32, zero32;
    state_t      st32;
    logic        sel32;

    assign din16 = din[15:0];

    cpu_gen2 #(.DW(16), .NREG(8)) u_dut16 (
        .Clock(clk), .Reset(rst), .DIN(din16), .Run(run16),
        .Bus(bus16), .Done(done16), .Zero(zero16), .o_dbg_state(st16)
    );

    cpu_gen2 #(.DW(32), .NREG(16)) u_dut32 (
        .Clock(clk), .Reset(rst), .DIN(din), .Run(run32),
        .Bus(bus32), .Done(done32), .Zero(zero32), .o_dbg_state(st32)
    );

    logic [31:0] obs_bus;
    logic        obs_done, obs_zero;
    state_t      obs_state;
    assign obs_bus   = sel32 ? bus32 : {16'h0, bus16};
    assign obs_done  = sel32 ? done32 : done16;
    assign obs_zero  = sel32 ? zero32 : zero16;
    assign obs_state = sel32 ? st32 : st16;

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (16-bit instance) ----------------
    logic [15:0] m_regs [8];
    logic        m_z;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_z = 1'b1;
    endtask

    task automatic model_step(input logic [2:0] op, input int x, input int y, input logic [31:0] imm,
                              output logic [31:0] e_bus, output bit e_chk, output int e_lat);
        logic [15:0] a, b, r;
        a = m_regs[x];
        b = m_regs[y];
        r = 16'h0;
        e_chk = 1'b1;
        e_lat = 1;
        e_bus = 32'h0;
        if (op == OP_MV) begin
            e_bus = {16'h0, b};
            m_regs[x] = b;
        end else if (op == OP_MVI) begin
            e_bus = {16'h0, imm[15:0]};
            m_regs[x] = imm[15:0];
        end else if (op == OP_MVNZ) begin
            if (!m_z) begin
                e_bus = {16'h0, b};
                m_regs[x] = b;
            end else begin
                e_chk = 1'b0;
            end
        end else if (op == OP_NOP) begin
            e_bus = 32'h0;
        end else begin
            if (op == OP_ADD)      r = 16'((32'(a) + 32'(b)) % 65536);
            else if (op == OP_SUB) r = 16'((32'(a) + 65536 - 32'(b)) % 65536);
            else if (op == OP_AND) r = a & b;
            else                   r = a | b;
            e_bus = {16'h0, r};
            m_regs[x] = r;
            m_z = (r == 16'h0);
            e_lat = 3;
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_run(input logic v);
        if (sel32) run32 = v;
        else       run16 = v;
    endtask

    // Entered just after a rising edge with the DUT in T0. Returns the bus
    // value seen while Done was high and the latency; returns in the next T0.
    task automatic run_instr(input logic [2:0] op, input int x, input int y, input logic [31:0] imm,
                             input bit hold, output logic [31:0] o_bus, output int o_lat);
        logic [3:0] xb, yb;
        bit got;
        xb = 4'(x);
        yb = 4'(y);
        if (sel32) din = {21'h0, op, xb, yb};
        else       din = {25'h0, op, xb[2:0], yb[2:0]};
        set_run(1'b1);
        @(negedge clk);
        chk("t0_bus", obs_bus, 32'h0);
        chk("t0_done", {31'h0, obs_done}, 32'h0);
        chk("t0_state", 32'(obs_state), 32'(S_T0));
        @(posedge clk); #1;
        set_run(hold);
        din = imm;
        o_bus = 32'h0;
        o_lat = 0;
        got = 1'b0;
        while (!got && o_lat < 6) begin
            o_lat++;
            @(negedge clk);
            if (obs_done) begin
                got = 1'b1;
                o_bus = obs_bus;
            end
            @(posedge clk); #1;
        end
        if (!got) chk("done_timeout", 32'h0, 32'h1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]  op;
        int          x;
        int          y;
        logic [31:0] imm;
        bit          hold;
        bit          chk_bus;
        logic [31:0] bus;
        int          lat;
        logic        z;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input int x, input int y, input logic [31:0] imm,
                                input bit hold, input bit cb, input logic [31:0] bus, input int lat,
                                input logic z);
        vec_t v;
        v.op = op; v.x = x; v.y = y; v.imm = imm; v.hold = hold;
        v.chk_bus = cb; v.bus = bus; v.lat = lat; v.z = z;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] got_bus, e_bus;
        int          got_lat, e_lat;
        bit          e_chk;
        logic [2:0]  rop;
        int          rx, ry;

        rst = 1'b1; din = 32'h0; run16 = 1'b0; run32 = 1'b0; sel32 = 1'b0;
        model_reset();
        #3;
        chk("rst_bus16", {16'h0, bus16}, 32'h0);
        chk("rst_done16", {31'h0, done16}, 32'h0);
        chk("rst_zero16", {31'h0, zero16}, 32'h1);
        chk("rst_state16", 32'(st16), 32'(S_T0));
        chk("rst_bus32", bus32, 32'h0);
        chk("rst_zero32", {31'h0, zero32}, 32'h1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Idle with Run low: must stay in T0.
        repeat (2) begin
            @(negedge clk);
            chk("idle_state", 32'(st16), 32'(S_T0));
            @(posedge clk); #1;
        end

        // All registers cleared by reset.
        for (int k = 0; k < 8; k++) begin
            run_instr(OP_MV, k, k, 32'h0, 1'b0, got_bus, got_lat);
            chk("rst_reg", got_bus, 32'h0);
        end

        //                op       x  y  imm         hold cb bus          lat z
        tbl.push_back(mk(OP_MVI,  0, 0, 32'h00A5,   0,   1, 32'h00A5,   1,  1));
        tbl.push_back(mk(OP_MV,   0, 0, 32'h0,      1,   1, 32'h00A5,   1,  1));
        tbl.push_back(mk(OP_MVI,  0, 0, 32'h0005,   0,   1, 32'h0005,   1,  1));
        tbl.push_back(mk(OP_MVI,  1, 0, 32'h0003,   1,   1, 32'h0003,   1,  1));
        tbl.push_back(mk(OP_ADD,  0, 1, 32'h0,      1,   1, 32'h0008,   3,  0));
        tbl.push_back(mk(OP_MV,   0, 0, 32'h0,      1,   1, 32'h0008,   1,  0));
        tbl.push_back(mk(OP_SUB,  1, 1, 32'h0,      0,   1, 32'h0000,   3,  1));
        tbl.push_back(mk(OP_MV,   1, 1, 32'h0,      0,   1, 32'h0000,   1,  1));
        tbl.push_back(mk(OP_MVI,  2, 0, 32'h0000,   0,   1, 32'h0000,   1,  1));
        tbl.push_back(mk(OP_MVI,  3, 0, 32'h0001,   0,   1, 32'h0001,   1,  1));
        tbl.push_back(mk(OP_SUB,  2, 3, 32'h0,      0,   1, 32'hFFFF,   3,  0));
        tbl.push_back(mk(OP_MVNZ, 4, 2, 32'h0,      0,   1, 32'hFFFF,   1,  0));
        tbl.push_back(mk(OP_MV,   4, 4, 32'h0,      0,   1, 32'hFFFF,   1,  0));
        tbl.push_back(mk(OP_NOP,  6, 7, 32'h0,      0,   1, 32'h0000,   1,  0));
        tbl.push_back(mk(OP_AND,  4, 3, 32'h0,      0,   1, 32'h0001,   3,  0));
        tbl.push_back(mk(OP_OR,   2, 4, 32'h0,      0,   1, 32'hFFFF,   3,  0));
        tbl.push_back(mk(OP_ADD,  2, 3, 32'h0,      0,   1, 32'h0000,   3,  1));
        tbl.push_back(mk(OP_MVNZ, 5, 3, 32'h0,      0,   0, 32'h0,      1,  1));
        tbl.push_back(mk(OP_MV,   5, 5, 32'h0,      0,   1, 32'h0000,   1,  1));
        tbl.push_back(mk(OP_MV,   2, 2, 32'h0,      0,   1, 32'h0000,   1,  1));

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].imm, tbl[i].hold, got_bus, got_lat);
            model_step(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].imm, e_bus, e_chk, e_lat);
            if (tbl[i].chk_bus) chk("tbl_bus", got_bus, tbl[i].bus);
            chk("tbl_lat", 32'(got_lat), 32'(tbl[i].lat));
            chk("tbl_zero", {31'h0, zero16}, {31'h0, tbl[i].z});
        end

        // Reset in T2 of add R5,R6 aborts without write-back.
        run_instr(OP_MVI, 6, 0, 32'h0007, 1'b0, got_bus, got_lat);
        chk("pre_mvi_bus", got_bus, 32'h0007);
        din = {25'h0, OP_ADD, 3'd5, 3'd6};
        run16 = 1'b1;
        @(posedge clk); #1;
        run16 = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_t2", 32'(st16), 32'(S_T2));
        #2;
        rst = 1'b1;
        #1;
        chk("abort_state", 32'(st16), 32'(S_T0));
        chk("abort_bus", {16'h0, bus16}, 32'h0);
        chk("abort_done", {31'h0, done16}, 32'h0);
        chk("abort_zero", {31'h0, zero16}, 32'h1);
        repeat (2) begin
            @(negedge clk);
            chk("abort_done_hold", {31'h0, done16}, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_done_rel", {31'h0, done16}, 32'h0);
        chk("abort_state_rel", 32'(st16), 32'(S_T0));
        @(posedge clk); #1;
        run_instr(OP_MV, 5, 5, 32'h0, 1'b0, got_bus, got_lat);
        chk("abort_r5", got_bus, 32'h0);
        chk("abort_zero_after", {31'h0, zero16}, 32'h1);

        // Randomized instruction stream against the model.
        for (int n = 0; n < 80; n++) begin
            rop = 3'($urandom_range(0, 7));
            rx  = $urandom_range(0, 7);
            ry  = $urandom_range(0, 7);
            model_step(rop, rx, ry, {16'h0, 16'($urandom)}, e_bus, e_chk, e_lat);
            run_instr(rop, rx, ry, {16'h0, m_regs[rx]}, 1'($urandom_range(0, 1)), got_bus, got_lat);
            if (e_chk) chk("rnd_bus", got_bus, e_bus);
            chk("rnd_lat", 32'(got_lat), 32'(e_lat));
            chk("rnd_zero", {31'h0, zero16}, {31'h0, m_z});
        end
        run16 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            run_instr(OP_MV, k, k, 32'h0, 1'b0, got_bus, got_lat);
            chk("rnd_final_reg", got_bus, {16'h0, m_regs[k]});
        end

        // 32-bit / 16-register instance.
        sel32 = 1'b1;
        run_instr(OP_MVI, 15, 0, 32'hDEADBEEF, 1'b0, got_bus, got_lat);
        chk("w_mvi_bus", got_bus, 32'hDEADBEEF);
        chk("w_mvi_lat", 32'(got_lat), 32'd1);
        run_instr(OP_AND, 15, 15, 32'h0, 1'b0, got_bus, got_lat);
        chk("w_and_bus", got_bus, 32'hDEADBEEF);
        chk("w_and_lat", 32'(got_lat), 32'd3);
        chk("w_and_zero", {31'h0, zero32}, 32'h0);
        run_instr(OP_MV, 15, 15, 32'h0, 1'b0, got_bus, got_lat);
        chk("w_r15", got_bus, 32'hDEADBEEF);
        run_instr(OP_MV, 7, 7, 32'h0, 1'b0, got_bus, got_lat);
        chk("w_r7", got_bus, 32'h0);
        run_instr(OP_MVI, 8, 0, 32'h12345678, 1'b0, got_bus, got_lat);
        run_instr(OP_MV, 0, 8, 32'h0, 1'b0, got_bus, got_lat);
        chk("w_mv_r0_r8", got_bus, 32'h12345678);
        run_instr(OP_MV, 0, 0, 32'h0, 1'b0, got_bus, got_lat);
        chk("w_r0", got_bus, 32'h12345678);
        run_instr(OP_SUB, 15, 15, 32'h0, 1'b0, got_bus, got_lat);
        chk("w_sub_bus", got_bus, 32'h0);
        chk("w_sub_zero", {31'h0, zero32}, 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
